// File: rtl/cache_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : cache_pipe_stage
// Description : Valid/ready pipeline stage with a 2-entry skid buffer, sticky
//               address/data capture on stalled beats, flush and stall history.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_pipe_stage #(
    parameter int DATA_W      = 256,
    parameter int META_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int STALL_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_stall,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [META_W-1:0]      in_meta,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [META_W-1:0]      out_meta,
    output logic [1:0]             occ_o,
    output logic [STALL_DEPTH-1:0] stall_hist_o
);

    logic                   main_valid_q, main_valid_d;
    logic [DATA_W-1:0]      main_data_q,  main_data_d;
    logic [ADDR_W-1:0]      main_addr_q,  main_addr_d;
    logic [META_W-1:0]      main_meta_q,  main_meta_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]      skid_data_q,  skid_data_d;
    logic [ADDR_W-1:0]      skid_addr_q,  skid_addr_d;
    logic [META_W-1:0]      skid_meta_q,  skid_meta_d;
    logic [ADDR_W-1:0]      held_addr_q,  held_addr_d;
    logic [DATA_W-1:0]      held_data_q,  held_data_d;
    logic [1:0]             occ_q,        occ_d;
    logic [STALL_DEPTH-1:0] stall_hist_q, stall_hist_d;

    logic              w_acc;
    logic              w_drn;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [DATA_W-1:0] w_beat_data;

    always_comb begin
        in_ready     = ~skid_valid_q & ~flush;
        w_acc        = in_valid & in_ready;
        w_drn        = main_valid_q & out_ready;
        // A stalled beat carries the last non-stalled address/data forward
        w_beat_addr  = in_stall ? held_addr_q : in_addr;
        w_beat_data  = in_stall ? held_data_q : in_data;

        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_addr_d  = main_addr_q;
        main_meta_d  = main_meta_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_addr_d  = skid_addr_q;
        skid_meta_d  = skid_meta_q;
        held_addr_d  = held_addr_q;
        held_data_d  = held_data_q;

        if (w_acc && !in_stall) begin
            held_addr_d = in_addr;
            held_data_d = in_data;
        end

        if (!main_valid_q) begin
            if (w_acc) begin
                main_valid_d = 1'b1;
                main_data_d  = w_beat_data;
                main_addr_d  = w_beat_addr;
                main_meta_d  = in_meta;
            end
        end else if (w_drn) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_addr_d  = skid_addr_q;
                main_meta_d  = skid_meta_q;
                skid_valid_d = 1'b0;
            end else if (w_acc) begin
                main_data_d  = w_beat_data;
                main_addr_d  = w_beat_addr;
                main_meta_d  = in_meta;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = w_beat_data;
            skid_addr_d  = w_beat_addr;
            skid_meta_d  = in_meta;
        end

        // Flush kills whatever remains; a same-cycle drain has already happened
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    if (STALL_DEPTH == 1) begin : g_hist_single
        always_comb stall_hist_d = in_stall;
    end else begin : g_hist_multi
        always_comb stall_hist_d = {stall_hist_q[STALL_DEPTH-2:0], in_stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_addr_q  <= '0;
            main_meta_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_addr_q  <= '0;
            skid_meta_q  <= '0;
            held_addr_q  <= '0;
            held_data_q  <= '0;
            occ_q        <= 2'd0;
            stall_hist_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_addr_q  <= main_addr_d;
            main_meta_q  <= main_meta_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_addr_q  <= skid_addr_d;
            skid_meta_q  <= skid_meta_d;
            held_addr_q  <= held_addr_d;
            held_data_q  <= held_data_d;
            occ_q        <= occ_d;
            stall_hist_q <= stall_hist_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_addr     = main_addr_q;
    assign out_meta     = main_meta_q;
    assign occ_o        = occ_q;
    assign stall_hist_o = stall_hist_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_pipe_stage
// Description : Directed self-checking bench for cache_pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_pipe_stage;

    localparam int DATA_W      = 256;
    localparam int META_W      = 64;
    localparam int ADDR_W      = 32;
    localparam int STALL_DEPTH = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_stall;
    logic [DATA_W-1:0]      in_data;
    logic [ADDR_W-1:0]      in_addr;
    logic [META_W-1:0]      in_meta;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic [META_W-1:0]      out_meta;
    logic [1:0]             occ_o;
    logic [STALL_DEPTH-1:0] stall_hist_o;

    int checks   = 0;
    int failures = 0;

    cache_pipe_stage #(
        .DATA_W(DATA_W), .META_W(META_W), .ADDR_W(ADDR_W), .STALL_DEPTH(STALL_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_stall(in_stall),
        .in_data(in_data), .in_addr(in_addr), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_meta(out_meta),
        .occ_o(occ_o), .stall_hist_o(stall_hist_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [META_W-1:0] m, input logic s);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_meta  = m;
        in_stall = s;
    endtask

    // Protocol monitor, evaluated mid-cycle when inputs are stable
    logic              stab_pend = 1'b0;
    logic [ADDR_W-1:0] snap_addr;
    logic [DATA_W-1:0] snap_data;
    logic [META_W-1:0] snap_meta;

    always @(negedge clk) begin
        if (stab_pend) begin
            chk("stable_addr", 256'(out_addr), 256'(snap_addr));
            chk("stable_data", 256'(out_data), 256'(snap_data));
            chk("stable_meta", 256'(out_meta), 256'(snap_meta));
        end
        if (occ_o === 2'd3) chk("occ_max", 256'(occ_o), 256'(2));
        if (occ_o === 2'd2) chk("full_ready", 256'(in_ready), 256'(0));
        stab_pend = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0) && (flush === 1'b0);
        snap_addr = out_addr;
        snap_data = out_data;
        snap_meta = out_meta;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_stall = 1'b0;
        in_data = '0; in_addr = '0; in_meta = '0; out_ready = 1'b0;

        // Reset / idle
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_occ", 256'(occ_o), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_hist", 256'(stall_hist_o), 256'(0));
        chk("rst_out_addr", 256'(out_addr), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_meta", 256'(out_meta), 256'(0));

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(ADDR_W'(32'h100 + i), DATA_W'(i + 1), META_W'(i), 1'b0);
            tick();
            chk("stream_valid", 256'(out_valid), 256'(1));
            chk("stream_addr", 256'(out_addr), 256'(32'h100 + i));
            chk("stream_data", 256'(out_data), 256'(i + 1));
            chk("stream_occ", 256'(occ_o), 256'(1));
            chk("stream_ready", 256'(in_ready), 256'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 256'(out_valid), 256'(0));
        chk("stream_drain_occ", 256'(occ_o), 256'(0));

        // Backpressure into the skid entry
        out_ready = 1'b0;
        beat(32'hA0, 256'hA0A0, 64'h1, 1'b0);
        tick();
        chk("bp_occ1", 256'(occ_o), 256'(1));
        beat(32'hA4, 256'hA4A4, 64'h2, 1'b0);
        tick();
        chk("bp_occ2", 256'(occ_o), 256'(2));
        chk("bp_ready0", 256'(in_ready), 256'(0));
        beat(32'hA8, 256'hA8A8, 64'h3, 1'b0);
        tick();
        chk("bp_hold_occ", 256'(occ_o), 256'(2));
        chk("bp_head_a0", 256'(out_addr), 256'(32'hA0));
        out_ready = 1'b1;
        tick();
        chk("bp_head_a4", 256'(out_addr), 256'(32'hA4));
        chk("bp_head_a4_data", 256'(out_data), 256'(256'hA4A4));
        chk("bp_occ_after", 256'(occ_o), 256'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_head_a8", 256'(out_addr), 256'(32'hA8));
        chk("bp_head_a8_meta", 256'(out_meta), 256'(3));
        chk("bp_a8_valid", 256'(out_valid), 256'(1));
        tick();
        chk("bp_empty", 256'(out_valid), 256'(0));

        // Sticky address/data on stalled beats
        beat(32'h40, 256'h11, 64'h1, 1'b0);
        tick();
        chk("sticky_b1_addr", 256'(out_addr), 256'(32'h40));
        beat(32'h80, 256'h22, 64'h2, 1'b1);
        tick();
        chk("sticky_b2_addr", 256'(out_addr), 256'(32'h40));
        chk("sticky_b2_data", 256'(out_data), 256'(256'h11));
        chk("sticky_b2_meta", 256'(out_meta), 256'(2));
        beat(32'hC0, 256'h33, 64'h3, 1'b0);
        tick();
        chk("sticky_b3_addr", 256'(out_addr), 256'(32'hC0));
        chk("sticky_b3_data", 256'(out_data), 256'(256'h33));
        in_valid = 1'b0;
        in_stall = 1'b0;
        tick();

        // Flush with both entries full
        out_ready = 1'b0;
        beat(32'h200, 256'h55, 64'h4, 1'b0);
        tick();
        beat(32'h204, 256'h66, 64'h5, 1'b0);
        tick();
        chk("flush_pre_occ", 256'(occ_o), 256'(2));
        beat(32'h300, 256'h77, 64'h6, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 256'(in_ready), 256'(0));
        tick();
        flush = 1'b0;
        chk("flush_occ", 256'(occ_o), 256'(0));
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        out_ready = 1'b1;
        beat(32'h3FC, 256'h99, 64'h7, 1'b1);
        #1;
        chk("flush_ready_back", 256'(in_ready), 256'(1));
        tick();
        chk("flush_held_addr", 256'(out_addr), 256'(32'h204));
        chk("flush_held_data", 256'(out_data), 256'(256'h66));
        chk("flush_held_meta", 256'(out_meta), 256'(7));
        // Flush with room to spare must still refuse the offered beat
        beat(32'h500, 256'hAB, 64'h8, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush2_in_ready", 256'(in_ready), 256'(0));
        tick();
        flush = 1'b0;
        chk("flush2_occ", 256'(occ_o), 256'(0));
        beat(32'h600, 256'hCD, 64'h9, 1'b1);
        tick();
        chk("flush2_held_addr", 256'(out_addr), 256'(32'h204));
        chk("flush2_held_data", 256'(out_data), 256'(256'h66));
        in_valid = 1'b0;
        in_stall = 1'b0;
        tick(); tick(); tick();

        // Stall history shifting
        chk("hist_idle", 256'(stall_hist_o), 256'(3'b000));
        in_stall = 1'b1; tick();
        chk("hist_1", 256'(stall_hist_o), 256'(3'b001));
        in_stall = 1'b0; tick();
        chk("hist_2", 256'(stall_hist_o), 256'(3'b010));
        in_stall = 1'b0; tick();
        chk("hist_3", 256'(stall_hist_o), 256'(3'b100));
        in_stall = 1'b1; tick();
        chk("hist_4", 256'(stall_hist_o), 256'(3'b001));
        flush = 1'b1; in_stall = 1'b1; tick();
        flush = 1'b0;
        chk("hist_flush", 256'(stall_hist_o), 256'(3'b011));
        rst = 1'b1; in_stall = 1'b1; tick();
        rst = 1'b0; in_stall = 1'b0;
        chk("hist_rst", 256'(stall_hist_o), 256'(3'b000));
        chk("hist_rst_occ", 256'(occ_o), 256'(0));
        chk("hist_rst_addr", 256'(out_addr), 256'(0));
        tick();
        chk("hist_post_rst", 256'(stall_hist_o), 256'(3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
